// File: rtl/rvga_types.sv
// rvga shared types for the fetch stage.
// Fetch state encoding, word type and the canonical NOP.
package rvga_types;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IFETCH_IDLE,
    IFETCH_FETCH,
    IFETCH_DROP
  } ifetch_state_e;

  localparam word_t INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_t;

endpackage

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: one-entry holding register for a fetched word.
// Clear beats load, load beats drain.
module ifetch_buffer
  import rvga_types::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   load_i,
  input  logic   drain_i,
  input  logic   clear_i,
  input  fetch_t entry_i,
  output logic   valid_o,
  output fetch_t entry_o
);

  // hold one fetched {pc, instr} while decode is stalled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      entry_o <= {32'h0, INSTR_NOP};
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      entry_o <= entry_i;
    end else if (drain_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: PC owner, single-outstanding imem fetch, decode register.
// Optional RVGA_IFETCH_PERF_EN adds fetch/drop counters.
module ifetch
  import rvga_types::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_v_i,
  input  logic        flush_v_i,
  input  logic        redirect_v_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_read_v_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_v_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_v_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef RVGA_IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] drop_cnt_o
`endif
);

  ifetch_state_e state_q;
  word_t         pc_q;
  word_t         drop_pc_q;
  logic          buf_v;
  fetch_t        buf_q;
  logic          req;
  logic          take;

  // a request is live in DROP, or in FETCH with room to land it
  assign req = (state_q == IFETCH_DROP) ||
               (state_q == IFETCH_FETCH && !buf_v);
  assign imem_read_v_o = req;
  assign imem_addr_o = (state_q == IFETCH_DROP) ?
                       drop_pc_q : pc_q;

  // a response is kept only if fresh and not killed this cycle
  assign take = (state_q == IFETCH_FETCH) && req &&
                imem_resp_v_i && !redirect_v_i && !flush_v_i;

  ifetch_buffer u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (take && stall_v_i),
    .drain_i (!stall_v_i && buf_v),
    .clear_i (flush_v_i),
    .entry_i ({pc_q, imem_data_i}),
    .valid_o (buf_v),
    .entry_o (buf_q)
  );

  // fetch FSM: PC update and stale-request tracking
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IFETCH_IDLE;
      pc_q      <= RESET_PC;
      drop_pc_q <= RESET_PC;
    end else begin
      unique case (state_q)
        IFETCH_IDLE: begin
          state_q <= IFETCH_FETCH;
          if (redirect_v_i) pc_q <= redirect_pc_i;
        end
        IFETCH_FETCH: begin
          if (redirect_v_i) begin
            pc_q <= redirect_pc_i;
            if (req && !imem_resp_v_i) begin
              state_q   <= IFETCH_DROP;
              drop_pc_q <= pc_q;
            end
          end else if (take) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        IFETCH_DROP: begin
          if (redirect_v_i) pc_q <= redirect_pc_i;
          if (imem_resp_v_i) state_q <= IFETCH_FETCH;
        end
        default: state_q <= IFETCH_IDLE;
      endcase
    end
  end

  // decode-facing register: buffer first, then a direct response
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_v_o <= 1'b0;
      instr_o   <= INSTR_NOP;
      pc_o      <= 32'h0;
    end else if (flush_v_i) begin
      instr_v_o <= 1'b0;
      instr_o   <= INSTR_NOP;
    end else if (!stall_v_i) begin
      if (buf_v) begin
        instr_v_o <= 1'b1;
        instr_o   <= buf_q.instr;
        pc_o      <= buf_q.pc;
      end else if (take) begin
        instr_v_o <= 1'b1;
        instr_o   <= imem_data_i;
        pc_o      <= pc_q;
      end else begin
        instr_v_o <= 1'b0;
        instr_o   <= INSTR_NOP;
      end
    end
  end

`ifdef RVGA_IFETCH_PERF_EN
  logic deliver;
  logic discard;

  assign deliver = !flush_v_i && !stall_v_i && (buf_v || take);
  assign discard = req && imem_resp_v_i && !take;

  // delivered and discarded instruction counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_cnt_o <= 32'h0;
      drop_cnt_o  <= 32'h0;
    end else begin
      if (deliver) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (discard) drop_cnt_o <= drop_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: random + directed bench for ifetch.
// Behavioural model compared every cycle, literal pins on key points.
`timescale 1ns/1ps
module tb_ifetch;
  import rvga_types::*;

  localparam word_t RPC = 32'h0000_0100;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  logic  redir = 1'b0;
  word_t rpc = '0;
  logic  rsp_v = 1'b0;
  word_t rsp_d = '0;
  logic  inj = 1'b0;
  logic  resp_v;
  word_t resp_d;
  logic  read_v;
  word_t addr;
  logic  instr_v;
  word_t instr;
  word_t pc;
`ifdef RVGA_IFETCH_PERF_EN
  word_t fcnt;
  word_t dcnt;
`endif

  int nvec = 0;
  int nerr = 0;

  assign resp_v = rsp_v | inj;
  assign resp_d = inj ? 32'hDEAD_BEEF : rsp_d;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(RPC)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_v_i     (stall),
    .flush_v_i     (flush),
    .redirect_v_i  (redir),
    .redirect_pc_i (rpc),
    .imem_read_v_o (read_v),
    .imem_addr_o   (addr),
    .imem_resp_v_i (resp_v),
    .imem_data_i   (resp_d),
    .instr_v_o     (instr_v),
    .instr_o       (instr),
    .pc_o          (pc)
`ifdef RVGA_IFETCH_PERF_EN
    ,
    .fetch_cnt_o   (fcnt),
    .drop_cnt_o    (dcnt)
`endif
  );

  function automatic word_t mem(input word_t a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm,
                     input word_t act,
                     input word_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // memory: random latency per request, answers at posedge+1
  int  lat_min = 0;
  int  lat_max = 0;
  int  wait_n = 0;
  bit  busy = 1'b0;
  always @(posedge clk) begin
    #1;
    rsp_v = 1'b0;
    rsp_d = $urandom;
    if (rst_n && read_v) begin
      if (!busy) begin
        busy = 1'b1;
        wait_n = $urandom_range(lat_max, lat_min);
      end
      if (wait_n == 0) begin
        rsp_v = 1'b1;
        rsp_d = mem(addr);
        busy = 1'b0;
      end else begin
        wait_n--;
      end
    end else begin
      busy = 1'b0;
    end
  end

  // reference model: next-PC, stale flag, queue as holding slot
  typedef struct {
    word_t pc;
    word_t ins;
  } ent_t;
  ent_t  q[$];
  bit    m_run;
  bit    m_stale;
  word_t m_pc;
  word_t m_old;
  bit    o_v;
  word_t o_i;
  word_t o_pc;
  int    m_fc;
  int    m_dc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_run = 0; m_stale = 0;
      m_pc = RPC; m_old = RPC;
      o_v = 0; o_i = INSTR_NOP; o_pc = '0;
      m_fc = 0; m_dc = 0;
    end else begin
      bit   rq;
      bit   got;
      bit   disc;
      bit   tk;
      ent_t e;
      rq   = m_run && (m_stale || q.size() == 0);
      got  = rq && resp_v;
      disc = got && (m_stale || redir || flush);
      tk   = got && !disc;
      if (disc) m_dc++;
      if (flush) begin
        q.delete();
        o_v = 0; o_i = INSTR_NOP;
      end else if (!stall) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          o_v = 1; o_i = e.ins; o_pc = e.pc;
          m_fc++;
        end else if (tk) begin
          o_v = 1; o_i = resp_d; o_pc = m_pc;
          m_fc++;
        end else begin
          o_v = 0; o_i = INSTR_NOP;
        end
      end else if (tk) begin
        e.pc = m_pc; e.ins = resp_d;
        q.push_back(e);
      end
      if (!m_run) begin
        m_run = 1;
        if (redir) m_pc = rpc;
      end else begin
        if (redir && rq && !resp_v && !m_stale) begin
          m_stale = 1; m_old = m_pc;
        end else if (m_stale && resp_v) begin
          m_stale = 0;
        end
        if (redir) m_pc = rpc;
        else if (tk) m_pc = m_pc + 32'd4;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    bit e_rq;
    e_rq = m_run && (m_stale || q.size() == 0);
    chk("read_v", {31'h0, read_v}, {31'h0, e_rq});
    chk("addr", addr, m_stale ? m_old : m_pc);
    chk("instr_v", {31'h0, instr_v}, {31'h0, o_v});
    chk("instr", instr, o_i);
    chk("pc_o", pc, o_pc);
`ifdef RVGA_IFETCH_PERF_EN
    chk("fetch_cnt", fcnt, m_fc);
    chk("drop_cnt", dcnt, m_dc);
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "timeout");
  end

  initial begin
    bit    found;
`ifdef RVGA_IFETCH_PERF_EN
    word_t d0;
`endif
    // zero-wait sequential fetch from RESET_PC
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_read_v", {31'h0, read_v}, 32'h0);
    chk("rst_addr", addr, 32'h100);
    chk("rst_instr_v", {31'h0, instr_v}, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    @(negedge clk);
    chk("seq_req", {31'h0, read_v}, 32'h1);
    chk("seq_a0", addr, 32'h100);
    @(negedge clk);
    chk("seq_a1", addr, 32'h104);
    chk("seq_v1", {31'h0, instr_v}, 32'h1);
    chk("seq_p1", pc, 32'h100);
    chk("seq_i1", instr, mem(32'h100));
    @(negedge clk);
    chk("seq_a2", addr, 32'h108);
    chk("seq_p2", pc, 32'h104);

    // fixed 3-cycle latency
    lat_min = 2; lat_max = 2;
    repeat (12) step();

    // stall across responses
    lat_min = 0; lat_max = 0;
    step(); stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (4) step();

    // redirect over an outstanding request
    lat_min = 2; lat_max = 2;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (read_v && !resp_v) found = 1;
    end
    chk("d_find", {31'h0, found}, 32'h1);
`ifdef RVGA_IFETCH_PERF_EN
    d0 = dcnt;
`endif
    redir = 1'b1; rpc = 32'h200;
    step(); redir = 1'b0;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (read_v && addr == 32'h200) found = 1;
    end
    chk("d_newreq", {31'h0, found}, 32'h1);
`ifdef RVGA_IFETCH_PERF_EN
    chk("d_dropcnt", dcnt - d0, 32'h1);
`endif

    // flush + redirect with a buffered instruction
    lat_min = 0; lat_max = 0;
    step(); stall = 1'b1;
    repeat (3) step();
    flush = 1'b1; redir = 1'b1; rpc = 32'h300;
    step();
    flush = 1'b0; redir = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("f_v", {31'h0, instr_v}, 32'h0);
    chk("f_nop", instr, 32'h0000_0013);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (instr_v) found = 1;
    end
    chk("f_seen", {31'h0, found}, 32'h1);
    chk("f_pc", pc, 32'h300);

    // randomized traffic, including PC wrap targets
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      step();
      stall = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 29) == 0);
      redir = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      else
        rpc = $urandom & 32'hFFFF_FFFC;
    end
    stall = 1'b0; flush = 1'b0; redir = 1'b0;

    // reset mid-request, late response in IDLE
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (read_v) found = 1;
    end
    chk("r_req", {31'h0, found}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_read_v", {31'h0, read_v}, 32'h0);
    chk("r_addr", addr, 32'h100);
    chk("r_instr_v", {31'h0, instr_v}, 32'h0);
    chk("r_instr", instr, 32'h0000_0013);
    chk("r_pc", pc, 32'h0);
    step(); inj = 1'b1;
    step(); rst_n = 1'b1;
    step(); inj = 1'b0;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (instr_v) found = 1;
    end
    chk("r_seen", {31'h0, found}, 32'h1);
    chk("r_pc1", pc, 32'h100);
    chk("r_i1", instr, mem(32'h100));
`ifdef RVGA_IFETCH_PERF_EN
    chk("r_dropcnt", dcnt, 32'h0);
`endif
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
